// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: FSM state encodings,
// divider counter width and the execution-rate to period mapping.
package cpu_run_pkg;

    localparam int COUNTER_W = 28;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_HALT  = 3'd4
    } run_state_e;

    // Terminal count of the divider for a given rate select: P-1 with P = 2^(4*freq).
    // For freq=7 the shift overflows to 0 and the subtraction yields 2^28-1.
    function automatic logic [COUNTER_W-1:0] period_m1(input logic [2:0] freq_sel);
        logic [COUNTER_W-1:0] one_v;
        one_v = {{(COUNTER_W-1){1'b0}}, 1'b1};
        return (one_v << {freq_sel, 2'b00}) - one_v;
    endfunction

endpackage

// File: rtl/run_div.sv
// Execution-rate divider: registers the rate select, runs a 28-bit counter
// while the controller is in RUN and flags the terminal-count tick.
// A change of the registered rate gives one dead cycle and restarts the count.
module run_div
    import cpu_run_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] freq_i,
    input  logic       run_i,
    output logic       tick_o
);

    logic [2:0]           freq_q;
    logic                 chg_q;
    logic [COUNTER_W-1:0] cnt_q;
    logic [COUNTER_W-1:0] cnt_d;
    logic                 at_end_s;

    // Terminal-count decode, tick gating and next counter value.
    always_comb begin
        at_end_s = (cnt_q == period_m1(freq_q));
        tick_o   = run_i && !chg_q && at_end_s;
        if (!run_i || chg_q || at_end_s) begin
            cnt_d = {COUNTER_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(COUNTER_W-1){1'b0}}, 1'b1};
        end
    end

    // Rate register, rate-change flag and divider counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q <= 3'd0;
            chg_q  <= 1'b0;
            cnt_q  <= {COUNTER_W{1'b0}};
        end else begin
            freq_q <= freq_i;
            chg_q  <= (freq_i != freq_q);
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctl.sv
// CPU run controller: IDLE/RUN/PAUSE/STEP/HALT sequencing of instruction
// commits, with a rate divider for free-running mode and a commit counter.
module cpu_run_ctl
    import cpu_run_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  freq,
    input  logic        start,
    input  logic        step,
    input  logic        pause,
    input  logic        halt_req,
    output logic        exec_en,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    run_state_e  state_q;
    run_state_e  state_d;
    logic        tick_s;
    logic        exec_s;
    logic [31:0] count_q;
    logic [31:0] count_d;

    run_div u_div (
        .clk    (clk),
        .rst    (rst),
        .freq_i (freq),
        .run_i  (state_q == ST_RUN),
        .tick_o (tick_s)
    );

    // Commit enable decoded from the current state; forced low while in reset.
    always_comb begin
        exec_s = 1'b0;
        if (rst) begin
            exec_s = 1'b0;
        end else if (state_q == ST_STEP) begin
            exec_s = 1'b1;
        end else if (state_q == ST_RUN) begin
            exec_s = tick_s;
        end else begin
            exec_s = 1'b0;
        end
    end

    // Next-state logic; a committing halt instruction outranks a same-cycle pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (exec_s && halt_req) begin
                    state_d = ST_HALT;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Commit counter next value: wraps naturally at 32 bits.
    always_comb begin
        if (exec_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and commit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign exec_en     = exec_s;
    assign halted      = (state_q == ST_HALT);
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Randomized bench for cpu_run_ctl. The driver pushes the expected outputs of
// every cycle into a queue from an event-based reference model (mode plus the
// absolute cycle of the next commit); a monitor pops and compares on negedge.
module tb_cpu_run_ctl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_STEP  = 3;
    localparam int M_HALT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  freq = 3'd0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        pause = 1'b0;
    logic        halt_req = 1'b0;
    logic        exec_en;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] instr_count;

    typedef struct {
        bit          ex;
        bit          hl;
        logic [2:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int          m_mode  = M_IDLE;
    bit          m_valid = 1'b0;
    bit          m_dead  = 1'b0;
    int          m_fq    = 0;
    longint      m_nf    = 0;
    longint      m_cyc   = 0;
    logic [31:0] m_cnt   = 32'd0;
    int          cur_f   = 0;

    cpu_run_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .freq        (freq),
        .start       (start),
        .step        (step),
        .pause       (pause),
        .halt_req    (halt_req),
        .exec_en     (exec_en),
        .halted      (halted),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic longint per(input int f);
        return longint'(1) << (4 * f);
    endfunction

    // One clock cycle: drive inputs, push expected outputs, advance the model.
    task automatic cycle(input bit r, input int f, input bit s, input bit t,
                         input bit p, input bit h);
        exp_t e;
        bit   ex;
        int   mn;
        @(posedge clk);
        #1;
        rst = r; freq = f[2:0]; start = s; step = t; pause = p; halt_req = h;
        ex = !r && (m_mode == M_STEP ||
                    (m_mode == M_RUN && !m_dead && m_cyc == m_nf));
        if (m_valid) begin
            e.ex = ex; e.hl = (m_mode == M_HALT);
            e.st = m_mode[2:0]; e.cnt = m_cnt;
            sb_q.push_back(e);
        end
        if (r) begin
            mn = M_IDLE; m_cnt = 32'd0; m_fq = 0; m_dead = 1'b0; m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE, M_PAUSE: mn = s ? M_RUN : (t ? M_STEP : m_mode);
                M_RUN:   mn = (ex && h) ? M_HALT : (p ? M_PAUSE : M_RUN);
                M_STEP:  mn = h ? M_HALT : M_PAUSE;
                default: mn = M_HALT;
            endcase
            if (mn == M_RUN) begin
                if (m_mode != M_RUN) m_nf = m_cyc + per(f);
                else if (m_dead || ex) m_nf = m_cyc + per(m_fq);
            end
            if (ex) m_cnt = m_cnt + 32'd1;
            m_dead = (f != m_fq);
            m_fq = f;
        end
        m_mode = mn;
        m_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, cur_f, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs with the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            tests++;
            if (exec_en !== e.ex || halted !== e.hl || state !== e.st ||
                instr_count !== e.cnt) begin
                fails++;
                $display("FAIL cycle_check t=%0t got exec_en=%b halted=%b state=%0d count=%0d, expected exec_en=%b halted=%b state=%0d count=%0d",
                         $time, exec_en, halted, state, instr_count,
                         e.ex, e.hl, e.st, e.cnt);
            end
        end
    end

    initial begin
        // Reset, then start at cycle 5 with freq=0: commit every RUN cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_f = 0;
        idle(1);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        // Pause, then three steps four cycles apart
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
            idle(3);
        end
        // freq=1 free run: commits every 16 cycles
        cur_f = 1;
        idle(2);
        cycle(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(40);
        // Rate change mid-count: freq 1 -> 0
        cycle(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        cur_f = 0;
        idle(6);
        // Halt on a commit cycle, then start/step/pause are ignored
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        // Reset in HALT with start held high, then a later start resumes RUN
        cycle(1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0)
                cur_f = ($urandom_range(99) == 0) ? 2 : int'($urandom_range(1));
            cycle($urandom_range(299) == 0, cur_f,
                  $urandom_range(15) == 0, $urandom_range(15) == 0,
                  $urandom_range(19) == 0, $urandom_range(63) == 0);
        end
        @(posedge clk);
        @(posedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain_check pending=%0d expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctl.md
CPU_RUN_CTL -- requirements
Module: cpu_run_ctl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 freq  input  3  execution-rate select; period P = 2^(4*freq) clk cycles (freq=0 -> P=1, freq=7 -> P=2^28).
REQ-004 start  input  1  single-cycle pulse, pre-debounced; request free-running execution.
REQ-005 step  input  1  single-cycle pulse, pre-debounced; request exactly one instruction.
REQ-006 pause  input  1  single-cycle pulse, pre-debounced; stop free-running execution.
REQ-007 halt_req  input  1  datapath decode of syscall with $v0==10 for the current instruction.
REQ-008 exec_en  output  1  one-cycle commit enable to PC, register file and RAM write paths.
REQ-009 halted  output  1  high while in HALT.
REQ-010 state  output  3  encoded FSM state, for display.
REQ-011 instr_count  output  32  count of exec_en pulses since reset.

Function
REQ-012 FSM states: IDLE, RUN, PAUSE, STEP, HALT; encodings IDLE=0, RUN=1, PAUSE=2, STEP=3, HALT=4.
REQ-013 IDLE: start -> RUN; else step -> STEP; start wins when start and step are both high.
REQ-014 RUN: pause -> PAUSE; pause wins over a simultaneous start, step or divider tick; step ignored.
REQ-015 PAUSE: start -> RUN; else step -> STEP; pause ignored.
REQ-016 STEP: exec_en high for exactly its one cycle; next state PAUSE, or HALT if halt_req is high in that cycle.
REQ-017 HALT: terminal; no exec_en; start/step/pause ignored; only rst exits.
REQ-018 Divider counter (28 bit) is held at 0 outside RUN, counts up in RUN, and wraps to 0 when it equals P-1.
REQ-019 In RUN, exec_en = (counter == P-1); freq=0 gives exec_en on every RUN cycle.
REQ-020 Latency: start sampled at edge t -> RUN from t; first exec_en at cycle t+P-1 (freq=0: the first RUN cycle).
REQ-021 freq is registered; any change in the registered value clears the counter the next cycle, with no exec_en on that cycle.
REQ-022 halt_req is sampled only when exec_en is high; that instruction commits and is counted, the next state is HALT, and no further exec_en occurs.
REQ-023 halt_req with exec_en low is ignored.
REQ-024 A pause in the same cycle as an exec_en tick still lets that exec_en fire (combinational decode of the current state); the next state is PAUSE.
REQ-025 instr_count increments by 1 on every exec_en, wraps 0xFFFFFFFF -> 0, and holds otherwise.
REQ-026 exec_en is never high on two consecutive cycles unless state==RUN and P==1.

Reset
REQ-027 rst has priority over all inputs: state=IDLE, counter=0, registered freq=0, instr_count=0, exec_en=0, halted=0.
REQ-028 rst asserted mid-RUN or in HALT gives IDLE on the next cycle, with exec_en low during and after the reset cycle.

Structure
REQ-029 Package cpu_run_pkg holds the state encodings, the COUNTER_W=28 constant, and the freq-to-P mapping function.
REQ-030 One sub-module, run_div, holds the registered freq, the 28-bit counter and the tick decode; the FSM and instr_count sit in cpu_run_ctl.

Verification
REQ-031 rst, freq=0, start at cycle 5 -> exec_en high every cycle from cycle 5; instr_count=10 after 10 RUN cycles.
REQ-032 freq=1, start -> exec_en pulses exactly every 16 cycles, the first on the 16th RUN cycle.
REQ-033 From PAUSE, three step pulses 4 cycles apart -> exactly 3 single-cycle exec_en pulses; instr_count +3; state returns to 2.
REQ-034 RUN freq=0, halt_req high on exec_en cycle N -> instr_count includes N, halted=1 from N+1, no exec_en after N, start ignored.
REQ-035 RUN freq=1 with counter=10, freq changed to 0 -> one dead cycle, then exec_en every cycle.
REQ-036 rst during HALT with start high -> IDLE, instr_count=0; a later start resumes RUN.
